bat_loader: RTL and testbench

Program loader for the Bat Amateur CPU, driving the external side of the CPU's RAM load interface. It accepts a framed byte stream from an upstream byte source such as a UART receiver. While a frame is in progress it asserts HALT, assembles big-endian 16-bit words and writes each one into CPU RAM at consecutive addresses. When the frame is complete it releases HALT so the CPU restarts from reset.

---
 rtl/bat_loader_pkg.sv | 22 ++
 rtl/bat_loader_csum.sv | 26 ++
 rtl/bat_loader.sv | 131 +++++++++++++
 tb/tb_bat_loader.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/bat_loader_pkg.sv
// Shared types and constants for the Bat CPU program loader.
// No logic; no latency.
// No backpressure; declarations only.
package bat_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    WRITE,
    CHECK,
    FINISH
  } state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  localparam logic RAM_WRITE = 1'b1;
  localparam logic RAM_READ  = 1'b0;

endpackage

// File: rtl/bat_loader_csum.sv
// 8-bit modulo-256 running sum of frame data bytes with an equality compare.
// Sum updates one cycle after add; match is combinational on cmp_dat.
// No backpressure; add is honoured every cycle it is high.
module bat_loader_csum (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       add,
  input  logic [7:0] add_dat,
  input  logic [7:0] cmp_dat,
  output logic       match
);

  logic [7:0] sum;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sum <= 8'h00;
    end else if (add) begin
      sum <= sum + add_dat;
    end
  end

  assign match = (sum == cmp_dat);

endmodule

// File: rtl/bat_loader.sv
// Framed byte-stream loader into Bat CPU RAM; BAT_LOADER_CHECKSUM_EN adds a trailing checksum byte.
// 3 cycles per word at full rate (hi byte, lo byte, write); DONE one cycle after the last write.
// RX_READY drops during WRITE and FINISH; RX_VALID low stalls any receive state indefinitely.
module bat_loader
  import bat_loader_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter logic [7:0]  SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_VALID,
  output logic        RX_READY,
  output logic        HALT,
  output logic [15:0] LOAD_DATA,
  output logic [15:0] LOAD_ADDRESS,
  output logic        EXT_RAM_RW,
  output logic        EXT_RAM_EN,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR
);

`ifdef BAT_LOADER_CHECKSUM_EN
  localparam state_t TAIL_STATE = CHECK;
`else
  localparam state_t TAIL_STATE = FINISH;
`endif

  state_t      state, state_n;
  logic [7:0]  len_hi;
  logic [15:0] len_rem;
  logic        rx_fire;
  logic        sync_hit;
  logic        csum_ok;

  assign rx_fire  = RX_VALID && RX_READY;
  assign sync_hit = (state == IDLE) && rx_fire && (RX_DATA == SYNC_BYTE);

`ifdef BAT_LOADER_CHECKSUM_EN
  bat_loader_csum u_csum (
    .clk     (CLK),
    .rst     (RST),
    .clr     (sync_hit),
    .add     (rx_fire && ((state == DATA_HI) || (state == DATA_LO))),
    .add_dat (RX_DATA),
    .cmp_dat (RX_DATA),
    .match   (csum_ok)
  );
`else
  assign csum_ok = 1'b1;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (sync_hit) state_n = LEN_HI;
      LEN_HI:  if (rx_fire) state_n = LEN_LO;
      LEN_LO:  if (rx_fire) state_n = ({len_hi, RX_DATA} == 16'd0) ? TAIL_STATE : DATA_HI;
      DATA_HI: if (rx_fire) state_n = DATA_LO;
      DATA_LO: if (rx_fire) state_n = WRITE;
      WRITE:   state_n = (len_rem == 16'd1) ? TAIL_STATE : DATA_HI;
      CHECK:   if (rx_fire) state_n = csum_ok ? FINISH : IDLE;
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge CLK) begin
    if (RST) begin
      RX_READY     <= 1'b1;
      HALT         <= 1'b0;
      LOAD_DATA    <= 16'h0000;
      LOAD_ADDRESS <= BASE_ADDR;
      EXT_RAM_RW   <= RAM_READ;
      EXT_RAM_EN   <= 1'b0;
      BUSY         <= 1'b0;
      DONE         <= 1'b0;
      ERR          <= 1'b0;
      len_hi       <= 8'h00;
      len_rem      <= 16'h0000;
    end else begin
      RX_READY   <= (state_n != WRITE) && (state_n != FINISH);
      BUSY       <= (state_n != IDLE);
      DONE       <= (state_n == FINISH);
      EXT_RAM_EN <= (state_n == WRITE);
      EXT_RAM_RW <= (state_n == WRITE) ? RAM_WRITE : RAM_READ;

      // HALT survives a checksum failure; only a completed frame or reset releases it.
      if (state_n == FINISH) begin
        HALT <= 1'b0;
      end else if (sync_hit) begin
        HALT <= 1'b1;
      end

`ifdef BAT_LOADER_CHECKSUM_EN
      if (sync_hit) begin
        ERR <= 1'b0;
      end else if ((state == CHECK) && rx_fire && !csum_ok) begin
        ERR <= 1'b1;
      end
`else
      ERR <= 1'b0;
`endif

      case (state)
        IDLE:    if (sync_hit) LOAD_ADDRESS <= BASE_ADDR;
        LEN_HI:  if (rx_fire) len_hi <= RX_DATA;
        LEN_LO:  if (rx_fire) len_rem <= {len_hi, RX_DATA};
        DATA_HI: if (rx_fire) LOAD_DATA[15:8] <= RX_DATA;
        DATA_LO: if (rx_fire) LOAD_DATA[7:0] <= RX_DATA;
        WRITE: begin
          LOAD_ADDRESS <= LOAD_ADDRESS + 16'd1;
          len_rem      <= len_rem - 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bat_loader.sv
// Randomized scoreboard bench for bat_loader: frames are modelled as lists of expected (address, word) writes.
// A negedge monitor pops and compares every RAM write and DONE pulse against those queues.
module tb_bat_loader;
  import bat_loader_pkg::*;

  localparam logic [15:0] BASE = 16'hFFFE;
  localparam logic [7:0]  SYNC = 8'hA5;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  RX_DATA = 8'h00;
  logic        RX_VALID = 1'b0;
  logic        RX_READY, HALT, EXT_RAM_RW, EXT_RAM_EN, BUSY, DONE, ERR;
  logic [15:0] LOAD_DATA, LOAD_ADDRESS;

  always #5 CLK = ~CLK;

  bat_loader #(.BASE_ADDR(BASE), .SYNC_BYTE(SYNC)) dut (
    .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
    .HALT(HALT), .LOAD_DATA(LOAD_DATA), .LOAD_ADDRESS(LOAD_ADDRESS), .EXT_RAM_RW(EXT_RAM_RW),
    .EXT_RAM_EN(EXT_RAM_EN), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] wq[$];
  int          dq[$];
  bit          mon_on = 0;
  bit          gap_toggle = 0;
  bit          full_rate = 0;
  bit          force_a5 = 0;
  logic        prev_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (mon_on) begin
      if (EXT_RAM_EN) begin
        chk("en_single_cycle", 32'(prev_en), 32'd0);
        if (wq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: addr %h data %h, no write expected", LOAD_ADDRESS, LOAD_DATA);
        end else begin
          chk("write_addr_data", {LOAD_ADDRESS, LOAD_DATA}, wq.pop_front());
          chk("write_rw", 32'(EXT_RAM_RW), 32'(RAM_WRITE));
          chk("write_halt", 32'(HALT), 32'd1);
          chk("write_rx_ready", 32'(RX_READY), 32'd0);
        end
      end
      if (DONE) begin
        if (dq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: DONE high, no frame completion expected");
        end else begin
          void'(dq.pop_front());
          chk("done_writes_flushed", 32'(wq.size()), 32'd0);
          chk("done_halt", 32'(HALT), 32'd0);
          chk("done_err", 32'(ERR), 32'd0);
          chk("done_busy", 32'(BUSY), 32'd1);
        end
      end
      prev_en = EXT_RAM_EN;
    end
  end

  task automatic send_byte(input logic [7:0] b, output int waits);
    logic rdy;
    waits = 0;
    if (!full_rate) begin
      int gaps = gap_toggle ? 1 : (($urandom_range(0, 3) == 0) ? 1 : 0);
      repeat (gaps) begin
        RX_VALID = 1'b0;
        @(negedge CLK);
      end
    end
    RX_DATA  = b;
    RX_VALID = 1'b1;
    forever begin
      rdy = RX_READY;
      @(negedge CLK);
      if (rdy) break;
      waits++;
      if (waits > 50) begin
        vectors++;
        miscompares++;
        $display("FAIL rx_accept_timeout: byte %h not accepted, waited %0d cycles, limit 50", b, waits);
        break;
      end
    end
    RX_VALID = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit bad);
    logic [15:0] len;
    logic [15:0] word;
    logic [7:0]  sum;
    int          w;
    len = 16'(n);
    sum = 8'h00;
`ifdef BAT_LOADER_CHECKSUM_EN
    if (!bad) dq.push_back(1);
`else
    dq.push_back(1);
`endif
    send_byte(SYNC, w);
    send_byte(len[15:8], w);
    send_byte(len[7:0], w);
    for (int i = 0; i < n; i++) begin
      word = (i == 0 && force_a5) ? 16'hA5A5 : 16'($urandom);
      wq.push_back({BASE + 16'(i), word});
      sum = sum + word[15:8] + word[7:0];
      send_byte(word[15:8], w);
      if (full_rate && i > 0) chk("hi_byte_waits_one_write", 32'(w), 32'd1);
      send_byte(word[7:0], w);
    end
`ifdef BAT_LOADER_CHECKSUM_EN
    send_byte(bad ? sum + 8'd1 : sum, w);
`endif
  endtask

  task automatic wait_drain();
    int c = 0;
    while ((wq.size() != 0 || dq.size() != 0) && c < 300) begin
      @(negedge CLK);
      c++;
    end
    chk("drain_outstanding", 32'(wq.size() + dq.size()), 32'd0);
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    int          w;
    logic [7:0]  b;
    logic [15:0] word;
    repeat (3) @(negedge CLK);
    chk("rst_rx_ready", 32'(RX_READY), 32'd1);
    chk("rst_halt", 32'(HALT), 32'd0);
    chk("rst_load_data", 32'(LOAD_DATA), 32'd0);
    chk("rst_load_address", 32'(LOAD_ADDRESS), 32'(BASE));
    chk("rst_rw", 32'(EXT_RAM_RW), 32'(RAM_READ));
    chk("rst_en", 32'(EXT_RAM_EN), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_err", 32'(ERR), 32'd0);
    RST = 1'b0;
    mon_on = 1;
    @(negedge CLK);

    // Non-sync bytes in IDLE are dropped without starting a frame.
    send_byte(8'h00, w);
    send_byte(8'hFF, w);
    send_byte(8'h5A, w);
    chk("junk_busy", 32'(BUSY), 32'd0);
    chk("junk_halt", 32'(HALT), 32'd0);

    send_frame(0, 0);
    wait_drain();

    // Full rate, leading A5 data word, and address wrap from FFFE through 0000.
    full_rate = 1;
    force_a5  = 1;
    send_frame(3, 0);
    wait_drain();
    full_rate = 0;
    force_a5  = 0;

`ifdef BAT_LOADER_CHECKSUM_EN
    send_frame(2, 1);
    wait_drain();
    chk("bad_csum_err", 32'(ERR), 32'd1);
    chk("bad_csum_halt", 32'(HALT), 32'd1);
    chk("bad_csum_busy", 32'(BUSY), 32'd0);
    send_frame(1, 0);
    wait_drain();
    chk("recover_err", 32'(ERR), 32'd0);
    chk("recover_halt", 32'(HALT), 32'd0);
`endif

    for (int f = 0; f < 6; f++) begin
      gap_toggle = ($urandom_range(0, 1) == 1);
      full_rate  = (f == 5);
      send_frame($urandom_range(1, 6), 0);
      wait_drain();
    end
    full_rate = 0;

    // Reset partway through the second word with RX_VALID toggling.
    gap_toggle = 1;
    word = 16'($urandom);
    wq.push_back({BASE, word});
    send_byte(SYNC, w);
    send_byte(8'h00, w);
    send_byte(8'h04, w);
    send_byte(word[15:8], w);
    send_byte(word[7:0], w);
    send_byte(8'h3C, w);
    chk("abort_first_write_seen", 32'(wq.size()), 32'd0);
    RST = 1'b1;
    @(negedge CLK);
    chk("abort_halt", 32'(HALT), 32'd0);
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_rx_ready", 32'(RX_READY), 32'd1);
    chk("abort_en", 32'(EXT_RAM_EN), 32'd0);
    RST = 1'b0;
    for (int k = 0; k < 4; k++) begin
      b = 8'($urandom);
      if (b == SYNC) b = 8'h00;
      send_byte(b, w);
    end
    repeat (20) @(negedge CLK);
    chk("abort_busy_after", 32'(BUSY), 32'd0);

    chk("final_writes_outstanding", 32'(wq.size()), 32'd0);
    chk("final_dones_outstanding", 32'(dq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation exceeded 400000 time units");
    $fatal(1, "global timeout");
  end

endmodule
